// File: rtl/dmem_pkg.sv
// Shared definitions for the RISC-V data memory: funct3 encodings, access size,
// legality check and byte-enable generation.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

    // One pipeline stage: the word is captured at the accept edge, extraction happens at the end.
    typedef struct packed {
        logic        valid;
        logic        fault;
        logic        is_load;
        logic [2:0]  funct3;
        logic [1:0]  offset;
        logic [31:0] word;
    } stage_t;

    function automatic size_e f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SIZE_B;
            2'b01:   return SIZE_H;
            default: return SIZE_W;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
        case (f3_size(f3))
            SIZE_B:  return 4'b0001 << a;
            SIZE_H:  return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Load data extraction: selects the addressed byte/half of a 32-bit word and
// sign- or zero-extends it according to funct3.
module dmem_load_extend
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = word >> {offset, 3'b000};

    always_comb begin
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   data = {24'h0, shifted[7:0]};
            F3_HU:   data = {16'h0, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/riscv_data_memory.sv
// Byte-addressed little-endian data memory with RISC-V load/store sizing and a
// valid/ready pipeline of READ_LATENCY stages. Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses.
module riscv_data_memory
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH_BYTES  = 4096,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_fault
);

    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam int WORDS = DEPTH_BYTES / 4;

    logic [31:0]      mem [WORDS];
    logic [IDX_W-1:0] idx;
    logic [IDX_W-3:0] word_idx;
    logic             addr_unused;
    size_e            req_size;
    logic [1:0]       req_offset;
    logic [31:0]      lane_data;
    logic [3:0]       be;
    logic             misaligned;
    logic             req_fault;
    logic             stall;
    logic             accept;
    logic             wr_en;
    stage_t           in_stage;
    stage_t           pipe [READ_LATENCY];
    stage_t           last;
    logic [31:0]      ext_data;

    // Upper address bits wrap around silently.
    assign idx         = req_addr[IDX_W-1:0];
    assign word_idx    = idx[IDX_W-1:2];
    assign addr_unused = ^req_addr[ADDR_WIDTH-1:IDX_W];
    assign req_size    = f3_size(req_funct3);

    always_comb begin
        // NOTE: every always_comb output is given a default first so no path can infer a latch.
        req_offset = 2'b00;
        lane_data  = req_wdata;
        case (req_size)
            SIZE_B: begin
                req_offset = idx[1:0];
                lane_data  = {4{req_wdata[7:0]}};
            end
            SIZE_H: begin
                req_offset = {idx[1], 1'b0};
                lane_data  = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misaligned = ((req_size == SIZE_H) && idx[0]) ||
                        ((req_size == SIZE_W) && (idx[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign req_fault = !f3_legal(req_we, req_funct3) || misaligned;
    assign stall     = rsp_valid && !rsp_ready;
    assign req_ready = !stall;
    assign accept    = req_valid && req_ready;
    assign wr_en     = accept && req_we && !req_fault;
    assign be        = byte_en(req_funct3, idx[1:0]);

    // NOTE: storage has no reset; contents survive rst_n and a reset port would block RAM inference.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        in_stage         = '0;
        in_stage.valid   = accept;
        in_stage.fault   = req_fault;
        in_stage.is_load = !req_we;
        in_stage.funct3  = req_funct3;
        in_stage.offset  = req_offset;
        in_stage.word    = mem[word_idx];
    end

    // All stages advance together; a stalled response freezes the whole pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
        end else if (!stall) begin
            pipe[0] <= in_stage;
            for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign last = pipe[READ_LATENCY-1];

    dmem_load_extend u_extend (
        .word   (last.word),
        .offset (last.offset),
        .funct3 (last.funct3),
        .data   (ext_data)
    );

    assign rsp_valid = last.valid;
    assign rsp_fault = last.valid && last.fault;
    assign rsp_rdata = (last.valid && last.is_load && !last.fault) ? ext_data : 32'h0;

endmodule

// File: tb/tb_riscv_data_memory.sv
// Self-checking bench for riscv_data_memory: directed vector table, hand-written
// stall/reset/latency sequences and random traffic against a byte-array reference model.
module tb_riscv_data_memory;
    import dmem_pkg::*;

    localparam int DEPTH = 4096;
    localparam int LAT   = 1;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    riscv_data_memory #(
        .ADDR_WIDTH   (32),
        .DEPTH_BYTES  (DEPTH),
        .READ_LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
    } exp_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  ref_mem [DEPTH];
    exp_t        exp_q [$];
    vec_t        vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory as a byte array, access rules applied with plain arithmetic.
    function automatic void model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] wd, output logic [31:0] rd, output logic flt);
        int     idx;
        int     size;
        int     base;
        bit     legal;
        longint val;
        idx   = int'(addr % DEPTH);
        size  = 1 << f3[1:0];
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        rd    = 32'h0;
        flt   = 1'b0;
        if (!legal || (TRAP && (idx % size) != 0)) begin
            flt = 1'b1;
            return;
        end
        base = idx - (idx % size);
        if (we) begin
            for (int k = 0; k < size; k++) ref_mem[base+k] = wd[8*k +: 8];
        end else begin
            val = 0;
            for (int k = 0; k < size; k++) val += longint'(ref_mem[base+k]) << (8*k);
            if (f3[2] == 1'b0 && size < 4 && val >= (longint'(1) << (8*size-1)))
                val -= longint'(1) << (8*size);
            rd = val[31:0];
        end
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                         input bit use_exp, input logic [31:0] xr, input logic xf);
        exp_t        e;
        logic [31:0] mr;
        logic        mf;
        bit          done_i = 1'b0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        for (int t = 0; t < 50 && !done_i; t++) begin
            @(negedge clk);
            if (req_ready) begin
                model_access(we, f3, addr, wd, mr, mf);
                e.rdata = use_exp ? xr : mr;
                e.fault = use_exp ? xf : mf;
                exp_q.push_back(e);
                done_i = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        check("req_accepted", 32'(done_i), 32'd1);
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) ok = 1'b1;
        end
        check("drain", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Response monitor: compares every visible response to the queue head, pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
                    check("rsp_fault", 32'(rsp_fault), 32'(exp_q[0].fault));
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] xr, input logic xf);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wd; v.exp_rdata = xr; v.exp_fault = xf;
        vecs.push_back(v);
    endtask

    task automatic latency_test();
        int k   = 1;
        bit got = 1'b0;
        wait_drain();
        issue(1'b0, F3_W, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
            else k++;
        end
        check("load_latency", 32'(k), 32'(LAT));
        @(posedge clk);
        #1;
        wait_drain();
    endtask

    task automatic stall_test();
        bit seen = 1'b0;
        rsp_ready = 1'b0;
        fork
            begin
                issue(1'b0, F3_W, 32'h8, 32'h0, 1'b0, 32'h0, 1'b0);
                issue(1'b0, F3_W, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0);
                issue(1'b0, F3_BU, 32'h13, 32'h0, 1'b0, 32'h0, 1'b0);
            end
            begin
                for (int t = 0; t < 20 && !seen; t++) begin
                    @(negedge clk);
                    if (rsp_valid) seen = 1'b1;
                end
                check("stall_rsp_seen", 32'(seen), 32'd1);
                for (int c = 0; c < 3; c++) begin
                    check("stall_req_ready", 32'(req_ready), 32'd0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic reset_test();
        issue(1'b1, F3_W, 32'h40, 32'h600DF00D, 1'b0, 32'h0, 1'b0);
        wait_drain();
        rsp_ready = 1'b0;
        issue(1'b1, F3_W, 32'h48, 32'h0BADCAFE, 1'b0, 32'h0, 1'b0);
        if (LAT == 2) issue(1'b0, F3_W, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check("inflight_before_reset", 32'(rsp_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_fault", 32'(rsp_fault), 32'd0);
        exp_q.delete();
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        issue(1'b0, F3_W, 32'h48, 32'h0, 1'b1, 32'h0BADCAFE, 1'b0);
        issue(1'b0, F3_W, 32'h40, 32'h0, 1'b1, 32'h600DF00D, 1'b0);
        wait_drain();
    endtask

    task automatic random_test(input int n);
        bit          done_r = 1'b0;
        logic [31:0] r;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    r = $urandom();
                    issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), r & 32'hFFFF_F0FF,
                          $urandom(), 1'b0, 32'h0, 1'b0);
                end
                done_r = 1'b1;
            end
            begin
                while (!done_r) begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                rsp_ready = 1'b1;
            end
        join
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b1;

        add(1'b1, F3_W,   32'h8,        32'hDEADBEEF, 32'h0,        1'b0);
        add(1'b0, F3_W,   32'h8,        32'h0,        32'hDEADBEEF, 1'b0);
        add(1'b1, F3_W,   32'h10,       32'h11223344, 32'h0,        1'b0);
        add(1'b1, F3_B,   32'h11,       32'hABCDEF80, 32'h0,        1'b0);
        add(1'b0, F3_B,   32'h11,       32'h0,        32'hFFFFFF80, 1'b0);
        add(1'b0, F3_BU,  32'h11,       32'h0,        32'h00000080, 1'b0);
        add(1'b0, F3_H,   32'h10,       32'h0,        32'hFFFF8044, 1'b0);
        add(1'b0, F3_HU,  32'h10,       32'h0,        32'h00008044, 1'b0);
        add(1'b0, F3_BU,  32'h13,       32'h0,        32'h00000011, 1'b0);
        add(1'b1, F3_H,   32'h12,       32'h1234F00D, 32'h0,        1'b0);
        add(1'b0, F3_W,   32'h10,       32'h0,        32'hF00D8044, 1'b0);
        add(1'b0, F3_H,   32'h12,       32'h0,        32'hFFFFF00D, 1'b0);
        add(1'b1, F3_W,   32'h0,        32'hCAFE0123, 32'h0,        1'b0);
        add(1'b0, F3_H,   32'h3,        32'h0,        TRAP ? 32'h0 : 32'hFFFFCAFE, TRAP);
        add(1'b0, F3_HU,  32'h1,        32'h0,        TRAP ? 32'h0 : 32'h00000123, TRAP);
        add(1'b0, F3_W,   32'h11,       32'h0,        TRAP ? 32'h0 : 32'hF00D8044, TRAP);
        add(1'b1, F3_W,   32'h9,        32'h12345678, 32'h0,        TRAP);
        add(1'b0, F3_W,   32'h8,        32'h0,        TRAP ? 32'hDEADBEEF : 32'h12345678, 1'b0);
        add(1'b0, 3'b011, 32'h8,        32'h0,        32'h0,        1'b1);
        add(1'b0, 3'b110, 32'h8,        32'h0,        32'h0,        1'b1);
        add(1'b0, 3'b111, 32'h8,        32'h0,        32'h0,        1'b1);
        add(1'b1, 3'b100, 32'h10,       32'hFFFFFFFF, 32'h0,        1'b1);
        add(1'b1, 3'b111, 32'h10,       32'hFFFFFFFF, 32'h0,        1'b1);
        add(1'b1, 3'b011, 32'h10,       32'hFFFFFFFF, 32'h0,        1'b1);
        add(1'b0, F3_W,   32'h10,       32'h0,        32'hF00D8044, 1'b0);
        add(1'b0, F3_W,   32'hABCDE010, 32'h0,        32'hF00D8044, 1'b0);
        add(1'b1, F3_B,   32'h12345013, 32'h0000005A, 32'h0,        1'b0);
        add(1'b0, F3_BU,  32'h13,       32'h0,        32'h0000005A, 1'b0);
        add(1'b0, F3_B,   32'hFFFFF013, 32'h0,        32'h0000005A, 1'b0);
        add(1'b0, F3_H,   32'h12,       32'h0,        32'h00005A0D, 1'b0);

        #12;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Give every byte of the 0x000-0x0FF window a known value.
        for (int w = 0; w < 64; w++) issue(1'b1, F3_W, 32'(w * 4), $urandom(), 1'b0, 32'h0, 1'b0);
        wait_drain();

        foreach (vecs[i])
            issue(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 1'b1, vecs[i].exp_rdata, vecs[i].exp_fault);
        wait_drain();

        latency_test();
        stall_test();
        reset_test();
        random_test(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
